// File: rtl/fpu_issue_scheduler_pkg.sv
// Shared FP issue definitions: register/latency sizing, the FPU latency codes
// and the writeback reservation slot record.
package fpu_issue_scheduler_pkg;

  localparam int FP_REG_W    = 5;
  localparam int FPU_MAX_LAT = 7;
  localparam int FPU_CNT_W   = 3;

  // Latency codes reported by the FPU per op class; code 0 retires like code 1.
  typedef enum logic [2:0] {
    LAT_BYPASS = 3'd0,
    LAT_SGNJ   = 3'd1,
    LAT_CVT    = 3'd2,
    LAT_ADD    = 3'd3,
    LAT_MUL    = 3'd4,
    LAT_FMA    = 3'd5,
    LAT_DIV    = 3'd6,
    LAT_SQRT   = 3'd7
  } fpu_lat_e;

  typedef struct packed {
    logic                valid;
    logic [FP_REG_W-1:0] rd;
  } fp_slot_t;

  function automatic logic [2:0] eff_lat(input logic [2:0] lat);
    return (lat == 3'd0) ? 3'd1 : lat;
  endfunction

endpackage

// File: rtl/fpu_issue_scheduler_if.sv
// EX-stage FP issue / writeback bundle between the pipeline and the scheduler.
interface fpu_issue_scheduler_if
  import fpu_issue_scheduler_pkg::*;
#(
  parameter int REG_W = FP_REG_W,
  parameter int CNT_W = FPU_CNT_W
) ();

  logic             issue_valid;
  logic             issue_writes_fp;
  logic [REG_W-1:0] issue_rd;
  logic [2:0]       issue_lat;
  logic [REG_W-1:0] issue_rs1;
  logic [REG_W-1:0] issue_rs2;
  logic [REG_W-1:0] issue_rs3;
  logic [2:0]       issue_rs_used;
  logic             fft_issue;
  logic             fft_busy;
  logic             flush;
  logic             stall;
  logic             issue_accept;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic [CNT_W-1:0] pending_count;

  modport master (
    output issue_valid, issue_writes_fp, issue_rd, issue_lat,
           issue_rs1, issue_rs2, issue_rs3, issue_rs_used,
           fft_issue, fft_busy, flush,
    input  stall, issue_accept, wb_valid, wb_rd, pending_count
  );

  modport slave (
    input  issue_valid, issue_writes_fp, issue_rd, issue_lat,
           issue_rs1, issue_rs2, issue_rs3, issue_rs_used,
           fft_issue, fft_busy, flush,
    output stall, issue_accept, wb_valid, wb_rd, pending_count
  );

endinterface

// File: rtl/fpu_issue_scheduler_fp_hazard_compare.sv
// Compares the EX op's sources and destination against the pending writeback
// slots, producing RAW and WAW hits.
module fp_hazard_compare
  import fpu_issue_scheduler_pkg::*;
#(
  parameter int MAX_LAT = FPU_MAX_LAT,
  parameter int REG_W   = FP_REG_W
) (
  input  fp_slot_t         slots [1:MAX_LAT],
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rs3,
  input  logic [2:0]       rs_used,
  input  logic [REG_W-1:0] rd,
  input  logic             writes_fp,
  output logic             raw_hit,
  output logic             waw_hit
);

  // Slot 1 retires this cycle and is forwarded, so it never causes RAW.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (slots[k].valid) begin
        if (k >= 2 && ((rs_used[0] && rs1 == slots[k].rd) ||
                       (rs_used[1] && rs2 == slots[k].rd) ||
                       (rs_used[2] && rs3 == slots[k].rd)))
          raw_hit = 1'b1;
        if (writes_fp && rd == slots[k].rd)
          waw_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_scheduler.sv
// FP issue controller: writeback reservation shift table, single FP writeback
// port, and stall generation for port conflicts, FP hazards and FFT busy.
module fpu_issue_scheduler
  import fpu_issue_scheduler_pkg::*;
#(
  parameter int MAX_LAT = FPU_MAX_LAT,
  parameter int REG_W   = FP_REG_W,
  parameter int CNT_W   = FPU_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  fpu_issue_scheduler_if.slave bus
);

  fp_slot_t         slots      [1:MAX_LAT];
  fp_slot_t         slots_next [1:MAX_LAT];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic [2:0]       leff;
  logic             port_conflict;
  logic             raw_hit;
  logic             waw_hit;
  logic             fft_hold;
  logic             stall_int;
  logic             accept_int;

  assign leff = eff_lat(bus.issue_lat);

  // The new entry lands in slot[Leff] next cycle, which is where slot[Leff+1] shifts to.
  always_comb begin
    port_conflict = 1'b0;
    for (int k = 2; k <= MAX_LAT; k++) begin
      if (bus.issue_writes_fp && k == int'(leff) + 1 && slots[k].valid)
        port_conflict = 1'b1;
    end
  end

  fp_hazard_compare #(
    .MAX_LAT (MAX_LAT),
    .REG_W   (REG_W)
  ) u_hazard (
    .slots     (slots),
    .rs1       (bus.issue_rs1),
    .rs2       (bus.issue_rs2),
    .rs3       (bus.issue_rs3),
    .rs_used   (bus.issue_rs_used),
    .rd        (bus.issue_rd),
    .writes_fp (bus.issue_writes_fp),
    .raw_hit   (raw_hit),
    .waw_hit   (waw_hit)
  );

  assign fft_hold   = bus.fft_issue && bus.fft_busy;
  assign stall_int  = (bus.issue_valid || bus.fft_issue) && !bus.flush &&
                      (port_conflict || raw_hit || waw_hit || fft_hold);
  assign accept_int = !rst && bus.issue_valid && !bus.flush && !stall_int;

  assign bus.stall         = !rst && stall_int;
  assign bus.issue_accept  = accept_int;
  assign bus.wb_valid      = !rst && slots[1].valid;
  assign bus.wb_rd         = bus.wb_valid ? slots[1].rd : '0;
  assign bus.pending_count = count_q;

  always_comb begin
    for (int k = 1; k < MAX_LAT; k++)
      slots_next[k] = slots[k + 1];
    slots_next[MAX_LAT] = '0;
    if (accept_int && bus.issue_writes_fp) begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (k == int'(leff))
          slots_next[k] = '{valid: 1'b1, rd: bus.issue_rd};
      end
    end
    count_next = '0;
    for (int k = 1; k <= MAX_LAT; k++)
      count_next = count_next + CNT_W'(slots_next[k].valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= MAX_LAT; k++)
        slots[k] <= '0;
      count_q <= '0;
    end else begin
      slots   <= slots_next;
      count_q <= count_next;
    end
  end

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, checked against
// a retire-time queue model of the FP writeback schedule.
module tb_fpu_issue_scheduler;
  import fpu_issue_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_issue_scheduler_if bus ();

  fpu_issue_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pend_rd  [$];
  int pend_ret [$];
  int m_stall, m_accept, m_wbv, m_wbrd, m_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Model: each pending result is just (rd, absolute retire cycle).
  task automatic modelEval();
    int  leff;
    bit  conflict, raw, waw;
    leff     = (bus.issue_lat == 3'd0) ? 1 : int'(bus.issue_lat);
    conflict = 0; raw = 0; waw = 0;
    m_wbv = 0; m_wbrd = 0;
    for (int i = 0; i < pend_ret.size(); i++) begin
      if (bus.issue_writes_fp && leff < FPU_MAX_LAT && pend_ret[i] == cyc + leff) conflict = 1;
      if (pend_ret[i] > cyc &&
          ((bus.issue_rs_used[0] && pend_rd[i] == int'(bus.issue_rs1)) ||
           (bus.issue_rs_used[1] && pend_rd[i] == int'(bus.issue_rs2)) ||
           (bus.issue_rs_used[2] && pend_rd[i] == int'(bus.issue_rs3)))) raw = 1;
      if (bus.issue_writes_fp && pend_rd[i] == int'(bus.issue_rd)) waw = 1;
      if (pend_ret[i] == cyc) begin m_wbv = 1; m_wbrd = pend_rd[i]; end
    end
    m_stall  = ((bus.issue_valid || bus.fft_issue) && !bus.flush &&
                (conflict || raw || waw || (bus.fft_issue && bus.fft_busy))) ? 1 : 0;
    m_accept = (bus.issue_valid && !bus.flush && m_stall == 0) ? 1 : 0;
    m_cnt    = pend_ret.size();
    if (rst) begin m_stall = 0; m_accept = 0; m_wbv = 0; m_wbrd = 0; end
  endtask

  task automatic checkAll();
    modelEval();
    checkOutput("stall", 32'(bus.stall), 32'(m_stall));
    checkOutput("issue_accept", 32'(bus.issue_accept), 32'(m_accept));
    checkOutput("wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
    checkOutput("wb_rd", 32'(bus.wb_rd), 32'(m_wbrd));
    if (!rst) checkOutput("pending_count", 32'(bus.pending_count), 32'(m_cnt));
  endtask

  task automatic tick();
    int leff;
    modelEval();
    leff = (bus.issue_lat == 3'd0) ? 1 : int'(bus.issue_lat);
    @(posedge clk);
    if (rst) begin
      pend_rd.delete();
      pend_ret.delete();
    end else begin
      if (m_accept == 1 && bus.issue_writes_fp) begin
        pend_rd.push_back(int'(bus.issue_rd));
        pend_ret.push_back(cyc + leff);
      end
      for (int i = pend_ret.size() - 1; i >= 0; i--)
        if (pend_ret[i] <= cyc) begin pend_ret.delete(i); pend_rd.delete(i); end
    end
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic wr, input logic [4:0] rd,
                               input logic [2:0] lat, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rs3,
                               input logic [2:0] used, input logic fi, input logic fb,
                               input logic fl);
    bus.issue_valid = iv; bus.issue_writes_fp = wr; bus.issue_rd = rd;
    bus.issue_lat = lat; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
    bus.issue_rs3 = rs3; bus.issue_rs_used = used; bus.fft_issue = fi;
    bus.fft_busy = fb; bus.flush = fl;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Step = check outputs mid-cycle, then advance one clock.
  task automatic step();
    #3;
    checkAll();
    tick();
  endtask

  int stall_cycles;
  bit accepted;

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    #3; checkAll(); tick();
    rst = 1'b0;
    #3;
    checkOutput("reset_pending", 32'(bus.pending_count), 32'd0);
    checkOutput("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    checkAll(); tick();

    $display("[TB] single op rd=3 lat=4");
    applyStimulus(1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 0);
    #3; checkOutput("t1_accept", 32'(bus.issue_accept), 32'd1); checkAll(); tick();
    idle();
    for (int i = 1; i <= 5; i++) begin
      #3;
      if (i == 4) begin
        checkOutput("t1_wb_valid", 32'(bus.wb_valid), 32'd1);
        checkOutput("t1_wb_rd", 32'(bus.wb_rd), 32'd3);
      end
      checkAll(); tick();
    end

    $display("[TB] writeback port conflict");
    applyStimulus(1, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 1, 6, 2, 0, 0, 0, 0, 0, 0, 0);
    #3; checkOutput("t2_stall", 32'(bus.stall), 32'd1); checkAll(); tick();
    #3; checkOutput("t2_accept", 32'(bus.issue_accept), 32'd1); checkAll(); tick();
    idle();
    #3; checkOutput("t2_wb_rd5", 32'(bus.wb_rd), 32'd5); checkAll(); tick();
    #3; checkOutput("t2_wb_rd6", 32'(bus.wb_rd), 32'd6); checkAll(); tick();
    step(); step();

    $display("[TB] RAW hazard on rd=8");
    applyStimulus(1, 1, 8, 5, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 1, 8, 0, 0, 3'b001, 0, 0, 0);
    stall_cycles = 0;
    accepted = 0;
    for (int i = 0; i < 12 && !accepted; i++) begin
      #3;
      if (bus.stall) stall_cycles++;
      if (bus.issue_accept) begin
        accepted = 1;
        checkOutput("t3_wb_rd_at_accept", 32'(bus.wb_rd), 32'd8);
      end
      checkAll(); tick();
    end
    checkOutput("t3_accepted", 32'(accepted), 32'd1);
    checkOutput("t3_stall_cycles", 32'(stall_cycles), 32'd4);
    idle(); step(); step();

    $display("[TB] FFT busy");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      #3; checkOutput("t4_fft_stall", 32'(bus.stall), 32'd1); checkAll(); tick();
    end
    bus.fft_busy = 1'b0;
    #3; checkOutput("t4_fft_release", 32'(bus.stall), 32'd0); checkAll(); tick();
    idle(); step();

    $display("[TB] flush of conflicting op");
    applyStimulus(1, 1, 10, 2, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("t5_flush_stall", 32'(bus.stall), 32'd0);
    checkOutput("t5_flush_accept", 32'(bus.issue_accept), 32'd0);
    checkAll(); tick();
    idle();
    #3; checkOutput("t5_wb_rd10", 32'(bus.wb_rd), 32'd10); checkAll(); tick();
    step(); step();

    $display("[TB] reset with pending entries");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 1, 5'(i + 12), 7, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    #3; checkOutput("t6_filled", 32'(bus.pending_count), 32'd3); checkAll();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3; checkOutput("t6_reset_pending", 32'(bus.pending_count), 32'd0); checkAll(); tick();
    for (int i = 0; i < 9; i++) begin
      #3; checkOutput("t6_no_wb", 32'(bus.wb_valid), 32'd0); checkAll(); tick();
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 9; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
